seq_generator: RTL and testbench

Serial pattern transmitter that acts as the stimulus source for the sequence detector. On a start request it latches a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock, repeating it a programmable number of times with a programmable idle gap between repetitions. Its `dout`/`dvalid` pair drives the detector's serial input. `busy`, `done` and `sent_cnt` report progress to the controlling logic.

---
 rtl/seq_generator.sv | 136 +++++++++++++
 tb/tb_seq_generator.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeating it
// reps times with a programmable idle gap; progress via busy/done/sent_cnt.
module seq_generator #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            reps_q   <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            reps_q   <= reps_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        reps_d  = reps_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    reps_d  = (reps == '0) ? CNT_W'(1) : reps;
                    gap_d   = gap;
                    cnt_d   = '0;
                    idx_d   = IDX_MAX;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (idx_q == '0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    idx_d = IDX_MAX;
                    if (cnt_d == reps_q) begin
                        state_d = S_DONE;
                    end else if (gap_q != '0) begin
                        gcnt_d  = gap_q;
                        state_d = S_GAP;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gcnt_q == GAP_W'(1)) begin
                    idx_d   = IDX_MAX;
                    state_d = S_SEND;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        dvalid_d = (state_d == S_SEND);
        dout_d   = (state_d == S_SEND) ? pat_d[idx_d] : 1'b0;
        busy_d   = (state_d == S_SEND) || (state_d == S_GAP);
        done_d   = (state_d == S_DONE);
    end

    assign dout     = dout_q;
    assign dvalid   = dvalid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sent_cnt = cnt_q;

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: per-edge expected output vectors written MSB = edge 1.
module tb_seq_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       abort;
    logic       dout;
    logic       dvalid;
    logic       busy;
    logic       done;
    logic [3:0] sent_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] snap [0:31];

    seq_generator #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .reps     (reps),
        .gap      (gap),
        .abort    (abort),
        .dout     (dout),
        .dvalid   (dvalid),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Vectors hold n bits; bit n-1-e is the stimulus sampled at edge e and the
    // output expectation observed just before edge e+1.
    task automatic run_seq(input string tag, input int n,
                           input logic [31:0] st_v, input logic [31:0] ab_v,
                           input logic [31:0] rs_v,
                           input logic [31:0] dv_v, input logic [31:0] do_v,
                           input logic [31:0] bs_v, input logic [31:0] dn_v);
        for (int e = 0; e < n; e++) begin
            start = st_v[n-1-e];
            abort = ab_v[n-1-e];
            rst   = rs_v[n-1-e];
            step();
            if (e == 0) begin
                pattern = ~pattern;
                reps    = reps + 4'd5;
                gap     = gap + 4'd7;
            end
            snap[e+1] = sent_cnt;
            chk($sformatf("%s.dvalid@%0d", tag, e+1), 32'(dvalid), 32'(dv_v[n-1-e]));
            chk($sformatf("%s.dout@%0d",   tag, e+1), 32'(dout),   32'(do_v[n-1-e]));
            chk($sformatf("%s.busy@%0d",   tag, e+1), 32'(busy),   32'(bs_v[n-1-e]));
            chk($sformatf("%s.done@%0d",   tag, e+1), 32'(done),   32'(dn_v[n-1-e]));
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        pattern = 4'b1111; reps = 4'd1; gap = 4'd0;
        @(negedge clk);

        // Reset held two cycles with start high
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("rst.dout%0d", i),   32'(dout),     32'd0);
            chk($sformatf("rst.dvalid%0d", i), 32'(dvalid),   32'd0);
            chk($sformatf("rst.busy%0d", i),   32'(busy),     32'd0);
            chk($sformatf("rst.done%0d", i),   32'(done),     32'd0);
            chk($sformatf("rst.cnt%0d", i),    32'(sent_cnt), 32'd0);
        end
        rst = 1'b0; start = 1'b0;
        step();
        chk("post_rst.dvalid", 32'(dvalid), 32'd0);
        chk("post_rst.busy",   32'(busy),   32'd0);

        // Single shot; a start while in DONE (edge 5) is ignored
        pattern = 4'b1011; reps = 4'd1; gap = 4'd0;
        run_seq("single", 6, 32'b100001, 32'b0, 32'b0,
                32'b111100, 32'b101100, 32'b111100, 32'b000010);
        chk("single.cnt", 32'(sent_cnt), 32'd1);

        // Three repetitions with a two-cycle gap
        pattern = 4'b1101; reps = 4'd3; gap = 4'd2;
        run_seq("gap", 18, 32'b100000000000000000, 32'b0, 32'b0,
                32'b111100111100111100, 32'b110100110100110100,
                32'b111111111111111100, 32'b000000000000000010);
        chk("gap.cnt@4",  32'(snap[4]),  32'd0);
        chk("gap.cnt@5",  32'(snap[5]),  32'd1);
        chk("gap.cnt@10", 32'(snap[10]), 32'd1);
        chk("gap.cnt@11", 32'(snap[11]), 32'd2);
        chk("gap.cnt@17", 32'(snap[17]), 32'd3);

        // Back-to-back repetitions
        pattern = 4'b1001; reps = 4'd2; gap = 4'd0;
        run_seq("b2b", 10, 32'b1000000000, 32'b0, 32'b0,
                32'b1111111100, 32'b1001100100, 32'b1111111100, 32'b0000000010);
        chk("b2b.cnt", 32'(sent_cnt), 32'd2);

        // reps=0 behaves as one repetition; gap is irrelevant
        pattern = 4'b0110; reps = 4'd0; gap = 4'd3;
        run_seq("reps0", 6, 32'b100000, 32'b0, 32'b0,
                32'b111100, 32'b011000, 32'b111100, 32'b000010);
        chk("reps0.cnt", 32'(sent_cnt), 32'd1);

        // Ignored restart at edge 3, abort at edge 7 in repetition 2, abort in IDLE at edge 9
        pattern = 4'b1100; reps = 4'd3; gap = 4'd1;
        run_seq("abort", 10, 32'b1001000000, 32'b0000000101, 32'b0,
                32'b1111011000, 32'b1100011000, 32'b1111111000, 32'b0000000000);
        chk("abort.cnt", 32'(sent_cnt), 32'd1);

        // Reset during GAP
        pattern = 4'b1011; reps = 4'd2; gap = 4'd3;
        run_seq("rstgap", 7, 32'b1000000, 32'b0, 32'b0000010,
                32'b1111000, 32'b1011000, 32'b1111100, 32'b0000000);
        chk("rstgap.cnt", 32'(sent_cnt), 32'd0);

        // Fresh transmission after the mid-flight reset
        pattern = 4'b0111; reps = 4'd1; gap = 4'd0;
        run_seq("fresh", 6, 32'b100000, 32'b0, 32'b0,
                32'b111100, 32'b011100, 32'b111100, 32'b000010);
        chk("fresh.cnt", 32'(sent_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
